// File: rtl/psram_responder_if.sv
// Byte-wide asynchronous PSRAM bus between the NES memory controller (master)
// and the block-RAM PSRAM stand-in (slave).
interface psram_responder_if;
  logic        RamCS;
  logic        MemOE;
  logic        MemWR;
  logic [23:0] MemAdr;
  logic [7:0]  MemDB_out;
  logic [7:0]  MemDB_in;

  modport master (
    output RamCS, MemOE, MemWR, MemAdr, MemDB_out,
    input  MemDB_in
  );

  modport slave (
    input  RamCS, MemOE, MemWR, MemAdr, MemDB_out,
    output MemDB_in
  );
endinterface

// File: rtl/psram_responder.sv
// Block-RAM stand-in for the board PSRAM: bus reads/writes plus a loader preload port.
// Optional macro PSRAM_ADDR_CHECK_EN flags and suppresses accesses above the array.
module psram_responder #(
  parameter int          MEM_ADDR_W   = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [7:0]  FILL         = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  psram_responder_if.slave      bus,
  input  logic                  load_we,
  input  logic [MEM_ADDR_W-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic                  load_ready,
  output logic                  proto_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_IGNORE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [MEM_ADDR_W-1:0]   r_addr;
  logic [23:0]             r_adr_full;
  logic [7:0]              r_wdata;
  logic                    r_oe;
  logic                    r_wr;
  logic                    r_bad;
  logic [2:0]              r_cnt;
  logic                    r_db_vld;
  logic                    r_proto_err;
  logic [7:0]              r_rd_q;
  logic [7:0]              r_mem [0:(2**MEM_ADDR_W)-1];

  logic                    w_s0_rd;
  logic                    w_s0_wr;
  logic                    w_s0_err;
  logic                    w_s0;
  logic                    w_commit;
  logic                    w_viol;
  logic                    w_hi_bad;
  logic [MEM_ADDR_W-1:0]   w_idx;

  assign w_idx = bus.MemAdr[MEM_ADDR_W-1:0];

`ifdef PSRAM_ADDR_CHECK_EN
  assign w_hi_bad = |bus.MemAdr[23:MEM_ADDR_W];
`else
  assign w_hi_bad = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_s0_rd     = 1'b0;
    w_s0_wr     = 1'b0;
    w_s0_err    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.RamCS) begin
          if (!bus.MemWR && bus.MemOE) begin
            w_state_nxt = ST_WRITE;
            w_s0_wr     = 1'b1;
          end else if (!bus.MemOE && bus.MemWR) begin
            w_state_nxt = ST_READ;
            w_s0_rd     = 1'b1;
          end else begin
            w_state_nxt = ST_IGNORE;
            w_s0_err    = 1'b1;
          end
        end
      end
      ST_READ:   if (bus.RamCS) w_state_nxt = ST_IDLE;
      ST_WRITE: begin
        if (bus.RamCS) begin
          w_state_nxt = ST_IDLE;
          w_commit    = !r_bad;
        end
      end
      ST_IGNORE: if (bus.RamCS) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_s0 = w_s0_rd | w_s0_wr | w_s0_err;

  // Bus signals must stay frozen while CS is low; write data only matters for writes.
  assign w_viol = ((r_state == ST_READ) || (r_state == ST_WRITE)) && !bus.RamCS &&
                  ((bus.MemAdr != r_adr_full) || (bus.MemOE != r_oe) ||
                   (bus.MemWR != r_wr) ||
                   ((r_state == ST_WRITE) && (bus.MemDB_out != r_wdata)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_adr_full  <= '0;
      r_wdata     <= '0;
      r_oe        <= 1'b1;
      r_wr        <= 1'b1;
      r_bad       <= 1'b0;
      r_cnt       <= '0;
      r_db_vld    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_s0) begin
        r_addr     <= w_idx;
        r_adr_full <= bus.MemAdr;
        r_wdata    <= bus.MemDB_out;
        r_oe       <= bus.MemOE;
        r_wr       <= bus.MemWR;
        r_bad      <= w_hi_bad;
        r_cnt      <= 3'd1;
      end

      if (w_s0_err || w_viol || (w_s0 && w_hi_bad)) r_proto_err <= 1'b1;

      if (w_s0_rd && !w_hi_bad && (READ_LATENCY == 1)) begin
        r_db_vld <= 1'b1;
      end else if (r_state == ST_READ) begin
        if (bus.RamCS) begin
          r_db_vld <= 1'b0;
        end else if (!r_db_vld) begin
          if (!r_bad && (r_cnt == LAT_M1)) r_db_vld <= 1'b1;
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  // NOTE: the array is deliberately not reset so it maps to block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (w_commit)     r_mem[r_addr]    <= r_wdata;
    else if (load_we) r_mem[load_addr] <= load_data;
    if (w_s0_rd)      r_rd_q           <= r_mem[w_idx];
  end

  assign bus.MemDB_in = r_db_vld ? r_rd_q : FILL;
  assign load_ready   = !w_commit;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_psram_responder.sv
// Directed + randomized bench for psram_responder with a flat-array reference model;
// a READ_LATENCY=3 twin sees the same bus to show the too-slow read case.
module tb_psram_responder;
  localparam int         AW   = 16;
  localparam logic [7:0] FILL = 8'hFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic          load_ready, proto_err, load_ready3, proto_err3;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [0:(2**AW)-1];
  logic [15:0] pool [0:7];

  psram_responder_if bus();
  psram_responder_if bus3();

  assign bus3.RamCS     = bus.RamCS;
  assign bus3.MemOE     = bus.MemOE;
  assign bus3.MemWR     = bus.MemWR;
  assign bus3.MemAdr    = bus.MemAdr;
  assign bus3.MemDB_out = bus.MemDB_out;

  psram_responder #(.MEM_ADDR_W(AW), .READ_LATENCY(2), .FILL(FILL)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .proto_err(proto_err)
  );

  psram_responder #(.MEM_ADDR_W(AW), .READ_LATENCY(3), .FILL(FILL)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready3), .proto_err(proto_err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_ok(input logic [23:0] adr);
`ifdef PSRAM_ADDR_CHECK_EN
    return (adr[23:16] == 8'h00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] exp_read(input logic [23:0] adr);
    return addr_ok(adr) ? model_mem[adr[15:0]] : FILL;
  endfunction

  task automatic model_write(input logic [23:0] adr, input logic [7:0] d);
    if (addr_ok(adr)) model_mem[adr[15:0]] = d;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic load(input logic [15:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
    model_mem[a] = d;
  endtask

  // CS low for 3 clocks; early = after S0, latched = what the initiator latches at S0+2.
  task automatic bus_cycle(input logic oe_n, input logic wr_n, input logic [23:0] adr,
                           input logic [7:0] d, output logic [7:0] early,
                           output logic [7:0] latched, output logic [7:0] latched3);
    bus.RamCS = 1'b0; bus.MemOE = oe_n; bus.MemWR = wr_n;
    bus.MemAdr = adr; bus.MemDB_out = d;
    @(posedge clk); #1 early = bus.MemDB_in;
    @(posedge clk); #1 latched = bus.MemDB_in; latched3 = bus3.MemDB_in;
    @(posedge clk); #1;
    bus.RamCS = 1'b1; bus.MemOE = 1'b1; bus.MemWR = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; #2;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] e, l, l3;
    logic [23:0] adr;
    logic [7:0]  d;
    logic        exp_pe;

    bus.RamCS = 1'b1; bus.MemOE = 1'b1; bus.MemWR = 1'b1;
    bus.MemAdr = '0; bus.MemDB_out = '0;

    #1;
    check("reset_db",    32'(bus.MemDB_in), 32'(FILL));
    check("reset_ready", 32'(load_ready),   32'd1);
    check("reset_perr",  32'(proto_err),    32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Preloaded read, latency 2
    load(16'h1234, 8'hA5);
    bus_cycle(1'b0, 1'b1, 24'h001234, 8'h00, e, l, l3);
    check("rd_early_fill", 32'(e), 32'(FILL));
    check("rd_latched",    32'(l), 32'hA5);
    check("rd_perr",       32'(proto_err), 32'd0);
    check("rd_idle_fill",  32'(bus.MemDB_in), 32'(FILL));

    // Write then read across a one-cycle CS gap
    bus_cycle(1'b1, 1'b0, 24'h000042, 8'h3C, e, l, l3);
    model_write(24'h000042, 8'h3C);
    bus_cycle(1'b0, 1'b1, 24'h000042, 8'h00, e, l, l3);
    check("b2b_read", 32'(l), 32'(model_mem[16'h0042]));

    // Preload colliding with a write commit
    load(16'h0020, 8'h00);
    bus.RamCS = 1'b0; bus.MemOE = 1'b1; bus.MemWR = 1'b0;
    bus.MemAdr = 24'h000010; bus.MemDB_out = 8'h11;
    repeat (3) begin @(posedge clk); #1; end
    bus.RamCS = 1'b1; bus.MemWR = 1'b1;
    load_we = 1'b1; load_addr = 16'h0020; load_data = 8'h77;
    #1;
    check("collide_ready0", 32'(load_ready), 32'd0);
    @(posedge clk); #1;
    check("collide_ready1", 32'(load_ready), 32'd1);
    @(posedge clk); #1 load_we = 1'b0;
    model_write(24'h000010, 8'h11);
    model_mem[16'h0020] = 8'h77;
    bus_cycle(1'b0, 1'b1, 24'h000020, 8'h00, e, l, l3);
    check("collide_load", 32'(l), 32'h77);
    bus_cycle(1'b0, 1'b1, 24'h000010, 8'h00, e, l, l3);
    check("collide_write", 32'(l), 32'h11);

    // Latency 3 misses the initiator's latch point and aborts silently
    load(16'h0300, 8'h5A);
    bus_cycle(1'b0, 1'b1, 24'h000300, 8'h00, e, l, l3);
    check("lat2_ok",      32'(l),  32'h5A);
    check("lat3_latched", 32'(l3), 32'(FILL));
    check("lat3_perr",    32'(proto_err3), 32'd0);
    check("lat3_idle",    32'(bus3.MemDB_in), 32'(FILL));

    // Randomized traffic against the model
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'h0400 + 16'(i * 37);
      load(pool[i], 8'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      adr[15:0] = pool[$urandom_range(0, 7)];
`ifdef PSRAM_ADDR_CHECK_EN
      adr[23:16] = 8'h00;
`else
      adr[23:16] = 8'($urandom);
`endif
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: load(adr[15:0], d);
        1: begin
          bus_cycle(1'b1, 1'b0, adr, d, e, l, l3);
          model_write(adr, d);
        end
        default: begin
          bus_cycle(1'b0, 1'b1, adr, 8'h00, e, l, l3);
          check("rand_early", 32'(e), 32'(FILL));
          check("rand_read",  32'(l), 32'(exp_read(adr)));
        end
      endcase
    end
    check("rand_perr", 32'(proto_err), 32'd0);

    // OE and WR both low: ignored, sticky error, memory untouched
    load(16'h0500, 8'h3E);
    bus_cycle(1'b0, 1'b0, 24'h000500, 8'h00, e, l, l3);
    check("both_low_db",   32'(l), 32'(FILL));
    check("both_low_perr", 32'(proto_err), 32'd1);
    bus_cycle(1'b0, 1'b1, 24'h000500, 8'h00, e, l, l3);
    check("both_low_mem",    32'(l), 32'h3E);
    check("perr_sticky",     32'(proto_err), 32'd1);

    // Reset in the middle of a write discards it
    load(16'h0600, 8'h77);
    bus.RamCS = 1'b0; bus.MemOE = 1'b1; bus.MemWR = 1'b0;
    bus.MemAdr = 24'h000600; bus.MemDB_out = 8'hC3;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    #2;
    check("midrst_db",    32'(bus.MemDB_in), 32'(FILL));
    check("midrst_perr",  32'(proto_err), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd1);
    bus.RamCS = 1'b1; bus.MemWR = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    bus_cycle(1'b0, 1'b1, 24'h000600, 8'h00, e, l, l3);
    check("midrst_mem",  32'(l), 32'h77);
    bus_cycle(1'b0, 1'b1, 24'h001234, 8'h00, e, l, l3);
    check("midrst_keep", 32'(l), 32'hA5);

    // Address change mid-read: flagged, captured address still used
    load(16'h0700, 8'h19);
    load(16'h0701, 8'h2A);
    bus.RamCS = 1'b0; bus.MemOE = 1'b0; bus.MemWR = 1'b1; bus.MemAdr = 24'h000700;
    @(posedge clk); #1 bus.MemAdr = 24'h000701;
    @(posedge clk); #1 l = bus.MemDB_in;
    @(posedge clk); #1 bus.RamCS = 1'b1; bus.MemOE = 1'b1;
    @(posedge clk); #1;
    check("chg_data", 32'(l), 32'h19);
    check("chg_perr", 32'(proto_err), 32'd1);
    pulse_reset();

    // High address bits: alias by default, rejected with the check enabled
    load(16'h0000, 8'h00);
    bus_cycle(1'b1, 1'b0, 24'h010000, 8'h99, e, l, l3);
    model_write(24'h010000, 8'h99);
`ifdef PSRAM_ADDR_CHECK_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    check("hi_perr", 32'(proto_err), 32'(exp_pe));
    bus_cycle(1'b0, 1'b1, 24'h010000, 8'h00, e, l, l3);
    check("hi_read", 32'(l), 32'(exp_read(24'h010000)));
    bus_cycle(1'b0, 1'b1, 24'h000000, 8'h00, e, l, l3);
    check("hi_low_mem", 32'(l), 32'(model_mem[16'h0000]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
